// File: rtl/param_register_file_pkg.sv
// Shared types and default sizing for the parameterised register file.
// Holds the bulk-clear FSM state encoding.
package param_register_file_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_DEPTH    = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_ZERO_REG = 31;

endpackage

// File: rtl/param_register_file_rf_read_port.sv
// One combinational read port: row select, zero/out-of-range masking.
// Optional write-to-read bypass when RF_BYPASS_EN is defined.
module rf_read_port
    import param_register_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic [DEPTH*DATA_W-1:0] rows,
    input  logic [ADDR_W-1:0]       rs,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_sel,
    input  logic [DATA_W-1:0]       wr_data,
    output logic [DATA_W-1:0]       rd
);

    always_comb begin
        rd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i != ZERO_REG && int'(rs) == i) begin
                rd = rows[i*DATA_W +: DATA_W];
            end
        end
`ifdef RF_BYPASS_EN
        // wr_en is already qualified against zero reg, range and clear
        if (wr_en && rs == wr_sel) begin
            rd = wr_data;
        end
`endif
    end

`ifndef RF_BYPASS_EN
    logic unused_byp;
    assign unused_byp = ^{wr_en, wr_sel, wr_data};
`endif

endmodule

// File: rtl/param_register_file.sv
// Two-read/one-write register file with hardwired zero row and bulk clear.
// Optional same-cycle write bypass under RF_BYPASS_EN.
module param_register_file
    import param_register_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic              Clock,
    input  logic              RST,
    input  logic [ADDR_W-1:0] R1RS,
    input  logic [ADDR_W-1:0] R2RS,
    output logic [DATA_W-1:0] R1ReadData,
    output logic [DATA_W-1:0] R2ReadData,
    input  logic [ADDR_W-1:0] WRS,
    input  logic [DATA_W-1:0] WD,
    input  logic              SWE,
    input  logic              ClrReq,
    output logic              ClrBusy,
    output logic              ClrDone
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [DEPTH-1:0][DATA_W-1:0] rf;
    logic [DEPTH*DATA_W-1:0]      rows;
    clr_state_t                   state;
    logic [ADDR_W-1:0]            cnt;
    logic                         wr_ok;
    logic                         we;

    assign wr_ok = (int'(WRS) < DEPTH) && (int'(WRS) != ZERO_REG);
    assign we    = SWE && !ClrBusy && wr_ok;
    assign rows  = rf;

    always_ff @(posedge Clock or negedge RST) begin
        if (!RST) begin
            rf <= '0;
        end else if (ClrBusy) begin
            rf[cnt] <= '0;
        end else if (we) begin
            rf[WRS] <= WD;
        end
    end

    always_ff @(posedge Clock or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            cnt     <= '0;
            ClrBusy <= 1'b0;
            ClrDone <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ClrDone <= 1'b0;
                    if (ClrReq) begin
                        state   <= CLEAR;
                        cnt     <= '0;
                        ClrBusy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == LAST) begin
                        state   <= DONE;
                        cnt     <= '0;
                        ClrBusy <= 1'b0;
                        ClrDone <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    ClrDone <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    ClrBusy <= 1'b0;
                    ClrDone <= 1'b0;
                end
            endcase
        end
    end

    rf_read_port #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG)
    ) u_rp1 (
        .rows   (rows),
        .rs     (R1RS),
        .wr_en  (we),
        .wr_sel (WRS),
        .wr_data(WD),
        .rd     (R1ReadData)
    );

    rf_read_port #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG)
    ) u_rp2 (
        .rows   (rows),
        .rs     (R2RS),
        .wr_en  (we),
        .wr_sel (WRS),
        .wr_data(WD),
        .rd     (R2ReadData)
    );

endmodule
